// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   Time-setting controller for a 24-hour clock. Decodes debounced MODE /
//   SELECT / ADJUST key pulses into a NORM -> SEC -> HOUR -> MIN adjust
//   sequence. It issues one-cycle SECCLR / MININC / HOURINC strobes to the
//   time counters and drives the per-field blink enables for the display. An
//   idle timeout returns the controller to NORM.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     When defined, holding ADJUST in HOUR or MIN auto-repeats the increment:
//     the first repeat comes REP_DLY cycles after the key pulse, and later
//     repeats follow every REP_PER cycles.
//     When undefined, each ADJUST pulse gives exactly one strobe.
//
// Parameters
//   TIMEOUT_SEC : EN1HZ pulses without key activity before returning to NORM (1..255)
//   REP_DLY     : clock cycles from the ADJUST pulse to the first repeat strobe
//   REP_PER     : clock cycles between later repeat strobes
//
// Ports
//   i_clk       : system clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_en1hz     : one-cycle pulse, once per second
//   i_sig2hz    : 2 Hz square wave used for blinking
//   i_mode      : MODE key pulse
//   i_select    : SELECT key pulse
//   i_adjust    : ADJUST key pulse
//   i_adjhold   : high while the ADJUST key is held
//   o_secclr    : clear-seconds strobe
//   o_mininc    : increment-minutes strobe
//   o_hourinc   : increment-hours strobe
//   o_secon     : seconds digits enable (1 = lit)
//   o_minon     : minutes digits enable
//   o_houron    : hours digits enable
//   o_adjmode   : high in any adjust state
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int TIMEOUT_SEC = 30,
    parameter int REP_DLY     = 25000000,
    parameter int REP_PER     = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en1hz,
    input  logic i_sig2hz,
    input  logic i_mode,
    input  logic i_select,
    input  logic i_adjust,
    input  logic i_adjhold,
    output logic o_secclr,
    output logic o_mininc,
    output logic o_hourinc,
    output logic o_secon,
    output logic o_minon,
    output logic o_houron,
    output logic o_adjmode
);

    typedef enum logic [1:0] {
        ST_NORM = 2'd0,
        ST_SEC  = 2'd1,
        ST_HOUR = 2'd2,
        ST_MIN  = 2'd3
    } state_t;

    // Reject parameter values the counters cannot represent.
    if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 255 || REP_DLY < 1 || REP_PER < 1) begin : g_param_check
        $error("time_set_ctrl: parameter out of range");
    end

    // The timeout fires on the EN1HZ pulse seen while the count sits one below the limit.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_SEC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    state_t     w_sel_nxt;
    logic [7:0] r_to_cnt;
    logic [7:0] w_to_cnt_nxt;
    logic       w_key;
    logic       w_in_adj;
    logic       w_timeout;
    logic       w_adj_acc;
    logic       w_rep_fire;
    logic       w_inc_strobe;
    logic       w_secclr_nxt;
    logic       w_mininc_nxt;
    logic       w_hourinc_nxt;

    logic       r_secclr;
    logic       r_mininc;
    logic       r_hourinc;
    logic       r_secon;
    logic       r_minon;
    logic       r_houron;
    logic       r_adjmode;

    assign w_key     = i_mode | i_select | i_adjust;
    assign w_in_adj  = (r_state != ST_NORM);
    // A key pulse or a held key clears the count, so it also blocks a coincident timeout.
    assign w_timeout = w_in_adj & i_en1hz & ~w_key & ~i_adjhold & (r_to_cnt == TO_LAST);

    // SELECT rotation order among the adjust fields.
    always_comb begin
        w_sel_nxt = ST_SEC;
        case (r_state)
            ST_SEC:  w_sel_nxt = ST_HOUR;
            ST_HOUR: w_sel_nxt = ST_MIN;
            ST_MIN:  w_sel_nxt = ST_SEC;
            default: w_sel_nxt = ST_SEC;
        endcase
    end

    // Next-state decode with MODE > SELECT > ADJUST priority.
    always_comb begin
        w_state_nxt = r_state;
        w_adj_acc   = 1'b0;
        case (r_state)
            ST_NORM: begin
                if (i_mode) begin
                    w_state_nxt = ST_SEC;
                end else begin
                    w_state_nxt = ST_NORM;
                end
            end
            ST_SEC, ST_HOUR, ST_MIN: begin
                if (i_mode) begin
                    w_state_nxt = ST_NORM;
                end else if (i_select) begin
                    w_state_nxt = w_sel_nxt;
                end else if (w_timeout) begin
                    w_state_nxt = ST_NORM;
                end else begin
                    w_state_nxt = r_state;
                    w_adj_acc   = i_adjust;
                end
            end
            default: begin
                w_state_nxt = ST_NORM;
            end
        endcase
    end

    // Idle timeout counter: runs on EN1HZ only while adjusting and untouched.
    always_comb begin
        if (w_state_nxt == ST_NORM || w_key || i_adjhold) begin
            w_to_cnt_nxt = 8'd0;
        end else if (i_en1hz) begin
            w_to_cnt_nxt = r_to_cnt + 8'd1;
        end else begin
            w_to_cnt_nxt = r_to_cnt;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY_C = REP_W'(REP_DLY);
    localparam logic [REP_W-1:0] REP_PER_C = REP_W'(REP_PER);
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0] REP_ZERO  = REP_W'(0);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_nxt;
    logic             r_rep_act;
    logic             w_rep_act_nxt;
    logic             r_rep_first;
    logic             w_rep_first_nxt;
    logic             w_rep_run;

    // Repeat timing: the count is 1 in the cycle after the ADJUST pulse,
    // so matching REP_DLY puts the registered strobe at pulse + 1 + REP_DLY.
    always_comb begin
        w_rep_run       = r_rep_act & i_adjhold & (w_state_nxt == r_state) & ~w_adj_acc;
        w_rep_fire      = 1'b0;
        w_rep_cnt_nxt   = r_rep_cnt;
        w_rep_act_nxt   = r_rep_act;
        w_rep_first_nxt = r_rep_first;
        if (w_adj_acc && (r_state == ST_HOUR || r_state == ST_MIN)) begin
            w_rep_cnt_nxt   = REP_ONE;
            w_rep_act_nxt   = 1'b1;
            w_rep_first_nxt = 1'b1;
        end else if (w_rep_run) begin
            if (r_rep_first ? (r_rep_cnt == REP_DLY_C) : (r_rep_cnt == REP_PER_C)) begin
                w_rep_fire      = 1'b1;
                w_rep_cnt_nxt   = REP_ONE;
                w_rep_first_nxt = 1'b0;
            end else begin
                w_rep_cnt_nxt   = r_rep_cnt + REP_ONE;
            end
        end else begin
            w_rep_cnt_nxt   = REP_ZERO;
            w_rep_act_nxt   = 1'b0;
            w_rep_first_nxt = 1'b0;
        end
    end

    // Repeat counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rep_cnt   <= REP_ZERO;
            r_rep_act   <= 1'b0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_act   <= w_rep_act_nxt;
            r_rep_first <= w_rep_first_nxt;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Only one field is adjustable per state, so the strobes are mutually exclusive.
    assign w_inc_strobe  = w_adj_acc | w_rep_fire;
    assign w_secclr_nxt  = w_adj_acc    & (r_state == ST_SEC);
    assign w_hourinc_nxt = w_inc_strobe & (r_state == ST_HOUR);
    assign w_mininc_nxt  = w_inc_strobe & (r_state == ST_MIN);

    // State, timeout counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_NORM;
            r_to_cnt  <= 8'd0;
            r_secclr  <= 1'b0;
            r_mininc  <= 1'b0;
            r_hourinc <= 1'b0;
            r_secon   <= 1'b1;
            r_minon   <= 1'b1;
            r_houron  <= 1'b1;
            r_adjmode <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_secclr  <= w_secclr_nxt;
            r_mininc  <= w_mininc_nxt;
            r_hourinc <= w_hourinc_nxt;
            r_secon   <= (w_state_nxt == ST_SEC)  ? i_sig2hz : 1'b1;
            r_minon   <= (w_state_nxt == ST_MIN)  ? i_sig2hz : 1'b1;
            r_houron  <= (w_state_nxt == ST_HOUR) ? i_sig2hz : 1'b1;
            r_adjmode <= (w_state_nxt != ST_NORM);
        end
    end

    assign o_secclr  = r_secclr;
    assign o_mininc  = r_mininc;
    assign o_hourinc = r_hourinc;
    assign o_secon   = r_secon;
    assign o_minon   = r_minon;
    assign o_houron  = r_houron;
    assign o_adjmode = r_adjmode;

endmodule
